// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the nibble-serial wide adder.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned NIB_W = 4;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIB_W;
  endfunction

  // Index width is ceil(log2(NIB)), never below one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned n;
    int unsigned w;
    n = nib_count(width);
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/add4_slice.sv
// 4-bit ripple adder slice; exposes every internal carry for overflow detection.
module add4_slice
  import wide_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic [NIB_W-1:0] cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    cout  = '0;
    carry = cin;
    for (int unsigned i = 0; i < NIB_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry;
      cout[i] = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      carry   = cout[i];
    end
  end

endmodule

// File: rtl/wide_add_seq.sv
// WIDTH-bit add/subtract sequenced through one 4-bit slice, LSB nibble first,
// with valid/ready handshakes on operands and result.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB  = nib_count(WIDTH);
  localparam int unsigned IDXW = idx_width(WIDTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              c_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [NIB_W-1:0]  a_nib;
  logic [NIB_W-1:0]  b_nib;
  logic [NIB_W-1:0]  s_sum;
  logic [NIB_W-1:0]  s_cout;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  add4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (c_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Working accumulator is separate from sum_q so the visible result stays
  // frozen until the next completion.
  always_comb begin
    acc_d = acc_q;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) acc_d[i*NIB_W +: NIB_W] = s_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            c_q     <= op_sub ? 1'b1 : cin;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          c_q   <= s_cout[NIB_W-1];
          if (idx_q == IDX_LAST) begin
            sum_q       <= acc_d;
            cout_q      <= s_cout[NIB_W-1];
            ovf_q       <= s_cout[NIB_W-1] ^ s_cout[NIB_W-2];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule
